// File: rtl/peaks_pkg.sv
// Shared defaults, peak record and controller state encoding for the SFFT peak finder.
package peaks_pkg;
    localparam int DEF_NFFT_LOG2   = 7;
    localparam int DEF_AMP_WIDTH   = 32;
    localparam int DEF_NBANDS_LOG2 = 3;
    localparam int DEF_RD_LAT      = 1;

    typedef struct packed {
        logic [DEF_NFFT_LOG2-1:0] bin;
        logic [DEF_AMP_WIDTH-1:0] amp;
    } peak_t;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMMIT} state_t;
endpackage

// File: rtl/peak_window3.sv
// Three-sample sliding window over the swept bins; flags the centre sample as a
// local-maximum candidate one cycle after the newest sample arrives.
module peak_window3 #(
    parameter int NFFT_LOG2 = 7,
    parameter int AMP_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [AMP_WIDTH-1:0] in_amp,
    input  logic [AMP_WIDTH-1:0] min_amp,
    output logic                 cand_valid,
    output logic [NFFT_LOG2-1:0] cand_bin,
    output logic [AMP_WIDTH-1:0] cand_amp
);
    logic [AMP_WIDTH-1:0] tap0, tap1, tap2;
    logic [NFFT_LOG2-1:0] newest_idx;
    logic                 shifted;
    logic                 is_peak;

    // Centre tap is bin newest_idx-1; requiring newest_idx >= 2 excludes bin 0,
    // and the last bin never reaches the centre before the frame ends.
    assign is_peak = shifted && (newest_idx >= NFFT_LOG2'(2)) &&
                     (tap1 > tap2) && (tap1 >= tap0) && (tap1 > min_amp);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tap0       <= '0;
            tap1       <= '0;
            tap2       <= '0;
            newest_idx <= '1;
            shifted    <= 1'b0;
            cand_valid <= 1'b0;
            cand_bin   <= '0;
            cand_amp   <= '0;
        end else if (clear) begin
            tap0       <= '0;
            tap1       <= '0;
            tap2       <= '0;
            newest_idx <= '1;
            shifted    <= 1'b0;
            cand_valid <= 1'b0;
            cand_bin   <= '0;
            cand_amp   <= '0;
        end else begin
            shifted <= in_valid;
            if (in_valid) begin
                tap0       <= in_amp;
                tap1       <= tap0;
                tap2       <= tap1;
                newest_idx <= newest_idx + NFFT_LOG2'(1);
            end
            cand_valid <= is_peak;
            cand_bin   <= newest_idx - NFFT_LOG2'(1);
            cand_amp   <= tap1;
        end
    end
endmodule

// File: rtl/sfft_peak_finder.sv
// Sweeps each new SFFT frame, keeps the strongest local maximum per band and publishes it.
// Optional PEAKS_HOLD_EN: commit stalls while the bus signals hold.
//
// state  | meaning
// IDLE   | waiting for a rising edge on sfft_valid
// SCAN   | issuing read addresses 0..N-1
// DRAIN  | collecting the last read returns and window output
// COMMIT | copying working peaks to the published set
module sfft_peak_finder
    import peaks_pkg::*;
#(
    parameter int NFFT_LOG2   = DEF_NFFT_LOG2,
    parameter int AMP_WIDTH   = DEF_AMP_WIDTH,
    parameter int NBANDS_LOG2 = DEF_NBANDS_LOG2,
    parameter int RD_LAT      = DEF_RD_LAT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sfft_valid,
    output logic [NFFT_LOG2-1:0]   sfft_addr,
    input  logic [AMP_WIDTH-1:0]   sfft_amp,
    input  logic [AMP_WIDTH-1:0]   min_amp,
    input  logic                   hold,
    input  logic [NBANDS_LOG2-1:0] rd_band,
    output logic [NFFT_LOG2-1:0]   rd_bin,
    output logic [AMP_WIDTH-1:0]   rd_amp,
    output logic [31:0]            frame_count,
    output logic [7:0]             overrun_count,
    output logic                   peaks_updated,
    output logic                   busy
);
    localparam int NBANDS  = 1 << NBANDS_LOG2;
    localparam int DRAIN_W = $clog2(RD_LAT + 2);

    state_t                 state;
    logic                   valid_q;
    logic                   start;
    logic                   commit_go;
    logic [RD_LAT-1:0]      issue_pipe;
    logic [DRAIN_W-1:0]     drain_cnt;
    logic                   cand_valid;
    logic [NFFT_LOG2-1:0]   cand_bin;
    logic [AMP_WIDTH-1:0]   cand_amp;
    logic [NBANDS_LOG2-1:0] cand_band;

    logic [NFFT_LOG2-1:0] work_bin   [NBANDS];
    logic [AMP_WIDTH-1:0] work_amp   [NBANDS];
    logic [NFFT_LOG2-1:0] work_bin_n [NBANDS];
    logic [AMP_WIDTH-1:0] work_amp_n [NBANDS];
    logic [NFFT_LOG2-1:0] pub_bin    [NBANDS];
    logic [AMP_WIDTH-1:0] pub_amp    [NBANDS];

    assign start     = sfft_valid && !valid_q;
    assign cand_band = cand_bin[NFFT_LOG2-1 -: NBANDS_LOG2];

`ifdef PEAKS_HOLD_EN
    assign commit_go = !hold;
`else
    logic unused_hold;
    assign unused_hold = hold;
    assign commit_go   = 1'b1;
`endif

    peak_window3 #(
        .NFFT_LOG2 (NFFT_LOG2),
        .AMP_WIDTH (AMP_WIDTH)
    ) u_window (
        .clk        (clk),
        .reset      (reset),
        .clear      ((state == IDLE) && start),
        .in_valid   (issue_pipe[RD_LAT-1]),
        .in_amp     (sfft_amp),
        .min_amp    (min_amp),
        .cand_valid (cand_valid),
        .cand_bin   (cand_bin),
        .cand_amp   (cand_amp)
    );

    // The commit publishes work_*_n so the final candidate lands in the same cycle.
    always_comb begin
        for (int b = 0; b < NBANDS; b++) begin
            work_bin_n[b] = work_bin[b];
            work_amp_n[b] = work_amp[b];
        end
        if (cand_valid && (cand_amp > work_amp[cand_band])) begin
            work_bin_n[cand_band] = cand_bin;
            work_amp_n[cand_band] = cand_amp;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            valid_q       <= 1'b0;
            issue_pipe    <= '0;
            drain_cnt     <= '0;
            sfft_addr     <= '0;
            rd_bin        <= '0;
            rd_amp        <= '0;
            frame_count   <= '0;
            overrun_count <= '0;
            peaks_updated <= 1'b0;
            busy          <= 1'b0;
            for (int b = 0; b < NBANDS; b++) begin
                work_bin[b] <= '0;
                work_amp[b] <= '0;
                pub_bin[b]  <= '0;
                pub_amp[b]  <= '0;
            end
        end else begin
            valid_q       <= sfft_valid;
            issue_pipe    <= RD_LAT'({issue_pipe, (state == SCAN)});
            peaks_updated <= 1'b0;
            rd_bin        <= pub_bin[rd_band];
            rd_amp        <= pub_amp[rd_band];
            work_bin      <= work_bin_n;
            work_amp      <= work_amp_n;

            if (start && (state != IDLE) && (overrun_count != 8'hFF))
                overrun_count <= overrun_count + 8'd1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SCAN;
                        busy      <= 1'b1;
                        sfft_addr <= '0;
                        for (int b = 0; b < NBANDS; b++) begin
                            work_bin[b] <= '0;
                            work_amp[b] <= '0;
                        end
                    end
                end
                SCAN: begin
                    if (sfft_addr == '1) begin
                        state     <= DRAIN;
                        sfft_addr <= '0;
                        drain_cnt <= DRAIN_W'(RD_LAT);
                    end else begin
                        sfft_addr <= sfft_addr + NFFT_LOG2'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0)
                        state <= COMMIT;
                    else
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                end
                COMMIT: begin
                    if (commit_go) begin
                        pub_bin       <= work_bin_n;
                        pub_amp       <= work_amp_n;
                        frame_count   <= frame_count + 32'd1;
                        peaks_updated <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sfft_peak_finder.sv
// Randomized and directed bench for sfft_peak_finder against a per-band peak reference model.
module tb_sfft_peak_finder;
    import peaks_pkg::*;

    localparam int N  = 128;
    localparam int NB = 8;
    localparam int BW = N / NB;

    logic        clk = 1'b0;
    logic        reset;
    logic        sfft_valid;
    logic [6:0]  sfft_addr;
    logic [31:0] sfft_amp;
    logic [31:0] min_amp;
    logic        hold;
    logic [2:0]  rd_band;
    logic [6:0]  rd_bin;
    logic [31:0] rd_amp;
    logic [31:0] frame_count;
    logic [7:0]  overrun_count;
    logic        peaks_updated;
    logic        busy;

    always #5 clk = ~clk;

    sfft_peak_finder dut (
        .clk           (clk),
        .reset         (reset),
        .sfft_valid    (sfft_valid),
        .sfft_addr     (sfft_addr),
        .sfft_amp      (sfft_amp),
        .min_amp       (min_amp),
        .hold          (hold),
        .rd_band       (rd_band),
        .rd_bin        (rd_bin),
        .rd_amp        (rd_amp),
        .frame_count   (frame_count),
        .overrun_count (overrun_count),
        .peaks_updated (peaks_updated),
        .busy          (busy)
    );

    // Upstream SFFT output memory with one cycle of read latency.
    logic [31:0] mem [N];
    always @(posedge clk) sfft_amp <= mem[sfft_addr];

    int          tests = 0;
    int          fails = 0;
    peak_t       exp_pub [NB];
    peak_t       new_pub [NB];
    logic [31:0] exp_frames;
    int          exp_over;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: scan every interior bin, keep the first strictly-largest peak per band.
    task automatic compute_model(input logic [31:0] thr);
        for (int b = 0; b < NB; b++) new_pub[b] = '0;
        for (int k = 1; k <= N - 2; k++) begin
            if (mem[k] > mem[k-1] && mem[k] >= mem[k+1] && mem[k] > thr &&
                mem[k] > new_pub[k / BW].amp) begin
                new_pub[k / BW].bin = 7'(k);
                new_pub[k / BW].amp = mem[k];
            end
        end
    endtask

    task automatic clear_mem();
        for (int k = 0; k < N; k++) mem[k] = '0;
    endtask

    task automatic check_readout(input string tag);
        for (int b = 0; b < NB; b++) begin
            rd_band = 3'(b);
            @(posedge clk); #1;
            check({tag, "_bin"}, 64'(rd_bin), 64'(exp_pub[b].bin));
            check({tag, "_amp"}, 64'(rd_amp), 64'(exp_pub[b].amp));
        end
    endtask

    task automatic run_frame(input string tag, input int restart_at, input bit toggle,
                             input int hold_len);
        int         lat;
        int         exp_lat;
        int         rises;
        logic [2:0] sel;
        peak_t      old;
        compute_model(min_amp);
        sel     = 3'($urandom_range(0, NB - 1));
        rd_band = sel;
        old     = exp_pub[sel];
        @(posedge clk); #1;
        rises = 0;
        lat   = -1;
`ifdef PEAKS_HOLD_EN
        exp_lat = N + 3 + hold_len;
`else
        exp_lat = N + 3;
`endif
        sfft_valid = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 400 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (c == 5) begin
                check({tag, "_addr5"}, 64'(sfft_addr), 64'd5);
                check({tag, "_busy_scan"}, 64'(busy), 64'd1);
            end
            if (toggle && c >= 3 && c <= 126) begin
                sfft_valid = (c % 2 == 1);
                if (c % 2 == 1) rises++;
            end else if (c == 2 || c == restart_at + 2 || c == 127) begin
                sfft_valid = 1'b0;
            end
            if (c == restart_at) begin
                sfft_valid = 1'b1;
                rises++;
            end
            if (c == N + 2) hold = (hold_len > 0);
            if (c == N + 2 + hold_len) hold = 1'b0;
            if (c == exp_lat - 1) begin
                check({tag, "_busy_pre"}, 64'(busy), 64'd1);
                check({tag, "_rd_pre"}, 64'(rd_amp), 64'(old.amp));
            end
            if (peaks_updated) begin
                lat = c;
                check({tag, "_latency"}, 64'(c), 64'(exp_lat));
                check({tag, "_frames"}, 64'(frame_count), 64'(exp_frames + 32'd1));
                check({tag, "_rd_old_bin"}, 64'(rd_bin), 64'(old.bin));
                check({tag, "_rd_old_amp"}, 64'(rd_amp), 64'(old.amp));
                check({tag, "_busy_done"}, 64'(busy), 64'd0);
                check({tag, "_addr_idle"}, 64'(sfft_addr), 64'd0);
            end
        end
        if (lat < 0) check({tag, "_pulse_seen"}, 64'd0, 64'd1);
        sfft_valid = 1'b0;
        hold       = 1'b0;
        for (int b = 0; b < NB; b++) exp_pub[b] = new_pub[b];
        exp_frames = exp_frames + 32'd1;
        exp_over   = (exp_over + rises > 255) ? 255 : exp_over + rises;
        @(posedge clk); #1;
        check({tag, "_pulse_width"}, 64'(peaks_updated), 64'd0);
        check({tag, "_rd_new_bin"}, 64'(rd_bin), 64'(exp_pub[sel].bin));
        check({tag, "_rd_new_amp"}, 64'(rd_amp), 64'(exp_pub[sel].amp));
        check({tag, "_overruns"}, 64'(overrun_count), 64'(exp_over));
        check_readout(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        reset      = 1'b1;
        sfft_valid = 1'b0;
        hold       = 1'b0;
        min_amp    = '0;
        rd_band    = '0;
        clear_mem();
        for (int b = 0; b < NB; b++) exp_pub[b] = '0;
        exp_frames = '0;
        exp_over   = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_frames", 64'(frame_count), 64'd0);
        check("rst_overrun", 64'(overrun_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pulse", 64'(peaks_updated), 64'd0);
        check("rst_addr", 64'(sfft_addr), 64'd0);
        check("rst_rd_amp", 64'(rd_amp), 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        clear_mem(); mem[20] = 1000;
        run_frame("impulse", -1, 1'b0, 0);

        clear_mem(); mem[35] = 500; mem[40] = 700;
        run_frame("band2_max", -1, 1'b0, 0);
        clear_mem(); mem[35] = 600; mem[40] = 600;
        run_frame("band2_tie", -1, 1'b0, 0);

        clear_mem(); mem[50] = 1000; min_amp = 1000;
        run_frame("thr_equal", -1, 1'b0, 0);
        mem[50] = 1001;
        run_frame("thr_above", -1, 1'b0, 0);
        min_amp = 0;

        clear_mem(); mem[0] = 32'hFFFF_FFFF; mem[N-1] = 32'hFFFF_FFFF;
        run_frame("edge_bins", -1, 1'b0, 0);
        mem[15] = 10; mem[16] = 50; mem[17] = 10;
        run_frame("bin16", -1, 1'b0, 0);

        clear_mem(); mem[70] = 77;
        run_frame("overrun40", 39, 1'b0, 0);
        clear_mem(); mem[90] = 9;
        run_frame("overrun_commit", N + 2, 1'b0, 0);
        clear_mem(); mem[100] = 123;
        run_frame("hold", -1, 1'b0, 10);

        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < N; k++)
                mem[k] = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 7));
            min_amp = 32'($urandom_range(0, 4));
            run_frame("random", -1, 1'b0, 0);
        end

        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < N; k++) mem[k] = 32'($urandom_range(0, 15));
            run_frame("toggle", -1, 1'b1, 0);
        end

        // Reset in the middle of a scan discards the frame.
        clear_mem(); mem[20] = 5000;
        rd_band = 3'd1;
        sfft_valid = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_frames", 64'(frame_count), 64'd0);
        check("midrst_overrun", 64'(overrun_count), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_addr", 64'(sfft_addr), 64'd0);
        check("midrst_rd_bin", 64'(rd_bin), 64'd0);
        check("midrst_rd_amp", 64'(rd_amp), 64'd0);
        sfft_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        pulses = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (peaks_updated) pulses++;
        end
        check("midrst_no_pulse", 64'(pulses), 64'd0);
        for (int b = 0; b < NB; b++) exp_pub[b] = '0;
        exp_frames = '0;
        exp_over   = 0;
        check_readout("midrst");

        clear_mem(); mem[20] = 1000;
        run_frame("after_reset", -1, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sfft_peak_finder.md
Name: sfft_peak_finder

Overview:
- Sits directly downstream of the SFFT pipeline and upstream of the bus readout buffer.
- On each new SFFT frame it sweeps the SFFT output memory through the pipeline's address/data read port and finds local-maximum bins above a threshold.
- Keeps the strongest peak per equal-width frequency band.
- Publishes a per-band peak list (bin index and amplitude) plus a frame counter for the driver to read.

Parameters:
- NFFT_LOG2, 7, log2 of the bin count N; swept addresses are 0..N-1.
- AMP_WIDTH, 32, bin amplitude width; unsigned magnitude.
- NBANDS_LOG2, 3, log2 of band count; band size is N >> NBANDS_LOG2.
- RD_LAT, 1, cycles from sfft_addr to sfft_amp valid.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sfft_valid  in  1  SFFT OutputValid; a rising edge marks a new frame
- sfft_addr  out  NFFT_LOG2  SFFT output_address
- sfft_amp  in  AMP_WIDTH  SFFT_OutReal data
- min_amp  in  AMP_WIDTH  peak threshold; a peak must be strictly greater
- hold  in  1  bus busy (chipselect); used only under PEAKS_HOLD_EN
- rd_band  in  NBANDS_LOG2  band select for readout
- rd_bin  out  NFFT_LOG2  published peak bin of rd_band, registered
- rd_amp  out  AMP_WIDTH  published peak amplitude of rd_band, registered
- frame_count  out  32  count of published frames
- overrun_count  out  8  saturating count of dropped frame starts
- peaks_updated  out  1  one-cycle pulse when published set changes
- busy  out  1  high from scan start until commit completes

Behaviour:
- Reset (async): all outputs 0, published and working arrays 0, state IDLE, edge-detect register 0.
- Frame start: sfft_valid is registered each cycle. A start is sfft_valid=1 with the previous sample 0.
- States:
  - IDLE: on a start, go to SCAN and clear the working array.
  - SCAN: sfft_addr issues 0..N-1, one per cycle, starting the cycle after the start. Data returns RD_LAT cycles later into a 3-sample window.
  - DRAIN: waits for the last RD_LAT returns.
  - COMMIT: copies working to published, increments frame_count, pulses peaks_updated, returns to IDLE.
- Peak rule: bin k is a candidate when all hold: 1 ≤ k ≤ N-2, a[k] > a[k-1], a[k] ≥ a[k+1], and a[k] > min_amp. Bins 0 and N-1 are never candidates.
- Band of bin k is k >> (NFFT_LOG2-NBANDS_LOG2). A candidate replaces its band's entry only if strictly greater, so on ties the lowest bin wins.
- Empty band publishes bin 0, amp 0.
- Latency: with no hold, peaks_updated and the new published values appear exactly N+RD_LAT+2 cycles after the cycle in which sfft_valid is first sampled 1 (131 at defaults).
- sfft_addr holds 0 outside SCAN.
- Overrun: a start seen while not in IDLE is dropped and overrun_count increments, saturating at 255. The current scan is unaffected.
- A start coincident with the COMMIT→IDLE cycle is also an overrun.
- Readout: rd_bin/rd_amp reflect published[rd_band] one cycle after rd_band changes. During the commit cycle the old values are shown; new values appear the next cycle.
- frame_count wraps at 2^32.
- Reset mid-scan: everything clears, no peaks_updated pulse, the frame is discarded.

Optional Feature:
- PEAKS_HOLD_EN, when defined:
  - COMMIT stalls while hold=1; publication occurs in the first cycle with hold=0.
  - peaks_updated is delayed accordingly, and busy stays high while stalled.
  - Starts during the stall count as overruns.
- When undefined: hold is ignored and COMMIT always takes one cycle.

Decomposition:
- peaks_pkg holds:
  - default NFFT_LOG2 / AMP_WIDTH / NBANDS_LOG2 constants;
  - typedef peak_t {bin, amp};
  - the state enum {IDLE, SCAN, DRAIN, COMMIT}.
- Sub-module peak_window3: 3-tap shift window plus the candidate compare. It outputs cand_valid, cand_bin and cand_amp one cycle after the newest sample.
- The top level holds the FSM, address counter, band tracker arrays, and counters.

Test Plan (defaults: N=128, 8 bands of 16, RD_LAT=1):
- Impulse amp 1000 at bin 20, all other bins 0, min_amp 0 → band1 = (20, 1000), other bands (0, 0), frame_count=1, peaks_updated 131 cycles after the start.
- Band2: bin35=500 and bin40=700 → (40, 700). Rerun with both at 600 → (35, 600).
- min_amp=1000 with a peak of 1000 → band empty. Peak of 1001 → published.
- Bins 0 and 127 = 0xFFFFFFFF with bins 1 and 126 = 0 → no peaks. Bin16=50 with bin15=10 and bin17=10 → band1 = (16, 50).
- Second sfft_valid edge 40 cycles into a scan → overrun_count=1, first frame still publishes. Reset asserted mid-scan → all outputs 0, no pulse.
- PEAKS_HOLD_EN defined, hold=1 for 10 cycles over the commit → peaks_updated delayed 10 cycles, old values readable until then.
